// File: rtl/mcu_spi_pkg.sv
// mcu_spi_pkg: shared constants and types for the MCU SPI slave.
// Byte/count widths, command byte index, select FSM states.
package mcu_spi_pkg;

  localparam int SPI_BYTE_W       = 8;
  localparam int SPI_CNT_W        = 32;
  localparam int SPI_CMD_BYTE_IDX = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEL  = 1'b1
  } spi_sel_e;

endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: SYNC_STAGES-deep synchroniser plus one edge flop.
// Ports: clk, rst_n, d (async in), q (synced), rise, fall (1-clk pulses).
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   q_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      q_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      q_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q    = sync_q[SYNC_STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/mcu_spi_slave.sv
// mcu_spi_slave: oversampled SPI mode-0 slave, byte strobes to mcu_cmd.
// Ports: sck/ssel_n/mosi pins in, miso/miso_oe out, tx_data in, cmd/param strobes+data, counts.
module mcu_spi_slave
  import mcu_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = SPI_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sck,
  input  logic                  ssel_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  output logic                  cmd_ready,
  output logic                  param_ready,
  output logic [SPI_BYTE_W-1:0] cmd_data,
  output logic [SPI_BYTE_W-1:0] param_data,
  output logic [CNT_W-1:0]      spi_byte_cnt,
  output logic [2:0]            spi_bit_cnt
);

  localparam logic [2:0] LAST_BIT = 3'(SPI_BYTE_W - 1);

  logic sck_s_unused;
  logic sck_rise;
  logic sck_fall;
  logic ssel_s;
  logic sel_start;
  logic sel_end;

  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   mosi_s;

  spi_sel_e sel_q;
  spi_sel_e sel_d;

  logic                  sel_ok;
  logic                  byte_done;
  logic [CNT_W-1:0]      cnt_nxt;
  logic [SPI_BYTE_W-1:0] rx_nxt;

  logic [SPI_BYTE_W-1:0] rx_sr;
  logic [SPI_BYTE_W-1:0] tx_sr;
  logic [SPI_BYTE_W-1:0] rx_byte_q;
  logic                  done_q;
  logic                  is_cmd_q;
  logic                  tx_pend;

  spi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sck_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sck),
    .q    (sck_s_unused),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  // ssel_n rising means deselect, falling means select
  spi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ssel_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ssel_n),
    .q    (ssel_s),
    .rise (sel_end),
    .fall (sel_start)
  );

  // Same depth as the SCK path so data lines up with sck_rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_q <= '0;
    end else begin
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
    end
  end

  assign mosi_s = mosi_q[SYNC_STAGES-1];

  // Only armed by a real select edge, so a reset
  // while ssel_n is low keeps the bus ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= ST_IDLE;
    end else begin
      sel_q <= sel_d;
    end
  end

  always_comb begin
    sel_d = sel_q;
    unique case (sel_q)
      ST_IDLE: if (sel_start) sel_d = ST_SEL;
      ST_SEL:  if (sel_end || ssel_s) sel_d = ST_IDLE;
    endcase
  end

  assign sel_ok    = (sel_q == ST_SEL) && !ssel_s;
  assign byte_done = sel_ok && sck_rise && (spi_bit_cnt == LAST_BIT);
  assign rx_nxt    = {rx_sr[SPI_BYTE_W-2:0], mosi_s};
  assign cnt_nxt   = (&spi_byte_cnt) ? spi_byte_cnt
                                     : spi_byte_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready    <= 1'b0;
      param_ready  <= 1'b0;
      cmd_data     <= '0;
      param_data   <= '0;
      miso_oe      <= 1'b0;
      spi_byte_cnt <= '0;
      spi_bit_cnt  <= '0;
      rx_sr        <= '0;
      tx_sr        <= '0;
      rx_byte_q    <= '0;
      done_q       <= 1'b0;
      is_cmd_q     <= 1'b0;
      tx_pend      <= 1'b0;
    end else begin
      cmd_ready   <= 1'b0;
      param_ready <= 1'b0;
      miso_oe     <= ~ssel_s;
      done_q      <= byte_done;

      // Byte and its kind were latched at completion,
      // so a deselect in between cannot corrupt the strobe.
      if (done_q) begin
        if (is_cmd_q) begin
          cmd_ready <= 1'b1;
          cmd_data  <= rx_byte_q;
        end else begin
          param_ready <= 1'b1;
          param_data  <= rx_byte_q;
        end
      end

      if (!sel_ok) begin
        spi_byte_cnt <= '0;
        spi_bit_cnt  <= '0;
        rx_sr        <= '0;
        tx_sr        <= '0;
        tx_pend      <= 1'b0;
      end else begin
        if (sck_rise) begin
          rx_sr       <= rx_nxt;
          spi_bit_cnt <= spi_bit_cnt + 3'd1;
          if (spi_bit_cnt == LAST_BIT) begin
            spi_byte_cnt <= cnt_nxt;
            rx_byte_q    <= rx_nxt;
            is_cmd_q     <= (cnt_nxt == CNT_W'(SPI_CMD_BYTE_IDX));
            tx_pend      <= 1'b1;
          end
        end
        if (sck_fall) begin
          if (tx_pend) begin
            tx_sr   <= tx_data;
            tx_pend <= 1'b0;
          end else begin
            tx_sr <= {tx_sr[SPI_BYTE_W-2:0], 1'b0};
          end
        end
      end
    end
  end

  assign miso = tx_sr[SPI_BYTE_W-1];

endmodule
